// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op encodings, FSM state type and helpers for the
//               multiply/divide unit controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam logic [1:0] MDU_MUL = 2'b01;
  localparam logic [1:0] MDU_DIV = 2'b10;

  localparam int DIV_CYCLES_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    DIV_ON = 2'd2,
    DONE   = 2'd3
  } mdu_state_e;

  // Magnitude of a 32-bit operand; only negated when treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration. quo_i holds
//               the remaining dividend bits (MSB next) with quotient bits
//               shifted in at the LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] dvs_i,
  input  logic [31:0] quo_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shift_w;
  logic [32:0] trial_w;

  // Bring down the next dividend bit; the partial remainder is always below
  // the divisor, so the shifted value fits in 33 bits.
  assign shift_w = {rem_i, quo_i[31]};
  assign trial_w = shift_w - {1'b0, dvs_i};

  // Keep the difference when it did not borrow, otherwise restore.
  always_comb begin
    rem_o = shift_w[31:0];
    quo_o = {quo_i[30:0], 1'b0};
    if (!trial_w[32]) begin
      rem_o = trial_w[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Multiply/divide unit controller. Single-cycle registered
//               multiply, iterative restoring divide, HI/LO result holding,
//               pipeline stall and annul handling.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic        sign_i,
  input  logic        annul_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        result_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_w;
  logic          last_w;

  // opa_q: multiplicand, or dividend magnitude shifting into quotient.
  // opb_q: multiplier, or divisor magnitude.
  logic [31:0] opa_q, opb_q, rem_q;
  logic        sign_q, negq_q, negr_q;
  logic [31:0] res_hi_q, res_lo_q;   // result of the op in flight
  logic [31:0] hi_q, lo_q;           // last committed result
  logic [31:0] step_rem_w, step_quo_w;
  logic signed [65:0] prod_w;
  logic        prod_unused;

  assign last_w = (cnt_q == CW'(DIV_CYCLES - 1));

  // Extended 33-bit operands make one signed multiplier cover both modes.
  assign prod_w = $signed({sign_q & opa_q[31], opa_q}) *
                  $signed({sign_q & opb_q[31], opb_q});
  assign prod_unused = ^prod_w[65:64];

  div_step u_div_step (
    .rem_i (rem_q),
    .dvs_i (opb_q),
    .quo_i (opa_q),
    .rem_o (step_rem_w),
    .quo_o (step_quo_w)
  );

  // State and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, accept qualification, stall and result pulse.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    accept_w       = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i && (op_i == MDU_MUL || op_i == MDU_DIV)) begin
          accept_w = 1'b1;
          stall_o  = 1'b1;
          cnt_d    = '0;
          if (op_i == MDU_MUL)    state_d = MUL;
          else if (opb_i == '0)   state_d = DONE;
          else                    state_d = DIV_ON;
        end
      end
      MUL: begin
        stall_o = 1'b1;
        state_d = annul_i ? IDLE : DONE;
      end
      DIV_ON: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last_w) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        result_valid_o = !annul_i;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  // In DONE the fresh result is shown; otherwise the committed one, which
  // is why an annulled op never disturbs HI/LO.
  assign hi_o = (state_q == DONE) ? res_hi_q : hi_q;
  assign lo_o = (state_q == DONE) ? res_lo_q : lo_q;

  // Operand capture, multiply/divide datapath and result commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      sign_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept_w) begin
        sign_q <= sign_i;
        rem_q  <= '0;
        if (op_i == MDU_MUL) begin
          opa_q <= opa_i;
          opb_q <= opb_i;
        end else begin
          opa_q  <= mag32(opa_i, sign_i);
          opb_q  <= mag32(opb_i, sign_i);
          negq_q <= sign_i & (opa_i[31] ^ opb_i[31]);
          negr_q <= sign_i & opa_i[31];
          if (opb_i == '0) begin
            res_hi_q <= opa_i;
            res_lo_q <= '1;
          end
        end
      end else if (state_q == MUL) begin
        res_hi_q <= prod_w[63:32];
        res_lo_q <= prod_w[31:0];
      end else if (state_q == DIV_ON) begin
        rem_q <= step_rem_w;
        opa_q <= step_quo_w;
        if (last_w) begin
          res_lo_q <= negq_q ? (~step_quo_w + 32'd1) : step_quo_w;
          res_hi_q <= negr_q ? (~step_rem_w + 32'd1) : step_rem_w;
        end
      end
      if (result_valid_o) begin
        hi_q <= res_hi_q;
        lo_q <= res_lo_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning the number of divider iteration cycles (one quotient bit per cycle).
REQ-002 SHALL have port clk, in, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, in, 1, asynchronous active-high reset.
REQ-004 SHALL have port start_i, in, 1, an MDU instruction is valid in EX (the decoder startDiv qualifier).
REQ-005 SHALL have port op_i, in, 2, operation code: 01 mult, 10 div, 00/11 none (same encoding as DataToHI/DataToLO).
REQ-006 SHALL have port sign_i, in, 1: 1 signed, 0 unsigned.
REQ-007 SHALL have port annul_i, in, 1, pipeline flush (exception or annul) that cancels any operation in flight.
REQ-008 SHALL have ports opa_i and opb_i, in, 32 each: rs and rt operands, where opa_i is the dividend or multiplicand.
REQ-009 SHALL have port stall_o, out, 1, which holds IF/ID/EX while an operation is incomplete.
REQ-010 SHALL have port busy_o, out, 1, high in any state other than IDLE.
REQ-011 SHALL have port result_valid_o, out, 1, a single-cycle pulse on which hi_o and lo_o are written to HILO.
REQ-012 SHALL have ports hi_o and lo_o, out, 32 each, holding the result; both are stable from the result_valid_o pulse until the next accept.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV_ON and DONE.
REQ-014 SHALL accept an operation only in IDLE, with start_i=1, op_i in {01,10} and annul_i=0; start_i in any other state is ignored.
REQ-015 SHALL drive stall_o = (IDLE & accept) | MUL | DIV_ON; stall_o SHALL be 0 in DONE.
REQ-016 SHALL register operands, op and sign on accept; the operand inputs are don't-care afterwards.
REQ-017 SHALL handle mult as follows: accept at T, then MUL at T+1 registers the 64-bit product, then DONE at T+2; hi_o is the upper 32 bits and lo_o the lower 32 bits.
REQ-018 SHALL handle div with opb≠0 as follows: accept at T, then DIV_ON for DIV_CYCLES cycles (counter 0..DIV_CYCLES-1, one restoring step per cycle), then DONE at T+DIV_CYCLES+1.
REQ-019 SHALL perform a signed div on magnitudes, then negate the quotient if the operand signs differ and negate the remainder if the dividend is negative; lo_o is the quotient and hi_o the remainder.
REQ-020 SHALL treat signed div of 0x80000000 by -1 as LO=0x80000000, HI=0, with no exception.
REQ-021 SHALL handle div with opb=0 by going from accept at T directly to DONE at T+1, with LO=0xFFFFFFFF and HI=opa.
REQ-022 SHALL, in DONE, assert result_valid_o=1 for exactly one cycle and then go to IDLE; start_i in DONE belongs to the same departing instruction and is ignored.
REQ-023 SHALL, when annul_i=1 in MUL, DIV_ON or DONE, go to IDLE next cycle with no result_valid_o pulse; in DONE, annul_i also forces result_valid_o=0 combinationally.
REQ-024 SHALL give annul_i priority over accept when both occur in the same IDLE cycle; stall_o is 0 in that cycle.
REQ-025 SHALL hold hi_o and lo_o unchanged when an operation is annulled.

Reset
REQ-026 SHALL, on rst=1, immediately and asynchronously set the state to IDLE, the counter to 0, stall_o, busy_o and result_valid_o to 0, and hi_o and lo_o to 0.
REQ-027 SHALL, if reset occurs mid-divide, drop the partial result, and the first post-reset accept SHALL start cleanly.

Structure
REQ-028 SHALL place op encodings (MDU_MUL=2'b01, MDU_DIV=2'b10), the state enum and DIV_CYCLES default in shared package mdu_pkg.
REQ-029 SHALL contain one sub-module, div_step, a combinational single restoring-division iteration (partial remainder, divisor, quotient bit in; updated remainder and quotient out), instantiated once and iterated by the FSM.
REQ-030 SHALL build the multiplier from the synthesis * operator on sign- or zero-extended 33-bit operands.

Verification
REQ-031 SHALL cover: signed mult opa=0xFFFFFFFF, opb=0xFFFFFFFF -> result_valid at T+2, HI=0x00000000, LO=0x00000001; unsigned mult of the same operands -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 SHALL cover: signed div opa=-7 (0xFFFFFFF9), opb=2 -> stall for 33 cycles, pulse at T+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF; unsigned div of the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
REQ-033 SHALL cover: div opa=0x12345678, opb=0 -> pulse at T+1, LO=0xFFFFFFFF, HI=0x12345678.
REQ-034 SHALL cover: annul_i at DIV_ON counter=10 -> IDLE next cycle, stall_o=0, no pulse, HI/LO unchanged; a new div accepted immediately after completes correctly.
REQ-035 SHALL cover: start_i held high through DONE -> exactly one pulse and no restart; rst asserted mid-DIV_ON -> all outputs 0 asynchronously.
REQ-036 SHALL cover: signed div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
